ctl_shot: RTL and testbench
===========================

Name: ctl_shot

Overview:
Downstream consumer of the duck position controller. Samples the player's trigger and crosshair position, tests the shot against the duck bounding box built from duck_x/duck_y/duck_show, and manages ammo, cooldown, hit flag and score. Outputs feed the draw stages (crosshair, flash, HUD) and the round controller.

Parameters:
DUCK_W, 64, duck bounding box width in pixels
DUCK_H, 64, duck bounding box height in pixels
AMMO_MAX, 3, shots per round, loaded on round_start
COOLDOWN_FRAMES, 8, new_frame pulses after a shot before the next trigger is accepted (1..63)
SCORE_MAX, 99, score saturation value
FLASH_FRAMES, 2, flash duration in new_frame pulses (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
new_frame  in  1  one-cycle pulse per video frame
round_start  in  1  one-cycle pulse: reload ammo, clear hit_latched
trigger  in  1  mouse left button, already synchronous to clk, level
mouse_x  in  11  crosshair x
mouse_y  in  11  crosshair y
duck_x  in  11  duck top-left x
duck_y  in  11  duck top-left y
duck_show  in  1  duck visible and shootable
shot_fired  out  1  one-cycle pulse per accepted shot
hit  out  1  one-cycle pulse, shot landed
miss  out  1  one-cycle pulse, shot missed
hit_latched  out  1  high from hit until round_start
ammo  out  2  remaining shots
out_of_ammo  out  1  ammo == 0
score  out  7  hits count, binary, saturating
flash  out  1  screen flash request

Behaviour:
- Reset (rst low, async): state IDLE, ammo=0, score=0, all pulses 0, hit_latched=0, flash=0, out_of_ammo=1, trigger_q=0.
- trigger_q registers trigger every cycle; rise = trigger & ~trigger_q.
- States: IDLE, ARMED, EVAL, COOLDOWN.
- IDLE: waits for round_start -> ARMED, ammo=AMMO_MAX.
- ARMED: rise with ammo>0 -> EVAL; same edge latches mouse_x/y, duck_x/y, duck_show; ammo decrements; shot_fired=1 for that one cycle. Rise with ammo==0 ignored.
- EVAL (one cycle): hit condition = latched duck_show & mx>=dx & mx<dx+DUCK_W & my>=dy & my<dy+DUCK_H; compare in 12-bit to prevent wrap at 2047. Registered hit or miss pulse on the next edge, i.e. 2 cycles after the rise is seen. Hit: hit_latched=1, score+1 saturating at SCORE_MAX. Next state COOLDOWN, counter cleared.
- COOLDOWN: counts new_frame pulses; on COOLDOWN_FRAMES-th pulse -> ARMED. Triggers ignored. A held trigger must be released and pressed again (edge only).
- round_start in any state except reset: ammo=AMMO_MAX, hit_latched=0, state ARMED, cooldown cleared; takes priority over a simultaneous rise (the shot is dropped, no pulse). Pulse for an EVAL in progress is suppressed. score not cleared by round_start.
- hit_latched blocks nothing; additional hits still score.
- out_of_ammo combinational from ammo register.
- Exactly one of hit/miss per shot_fired; never both.

Optional Feature:
Macro CTL_SHOT_FLASH_EN. Defined: flash goes high on the cycle after shot_fired and stays high for FLASH_FRAMES new_frame pulses; a new shot restarts the count. Undefined: flash tied to 0, no flash counter synthesised; all other behaviour identical.

Test Plan:
- Reset low mid-EVAL -> all outputs at reset values immediately, hit/miss never pulses; after release, ammo=0 until round_start.
- round_start, duck (100,200) shown, mouse (130,230), rise -> shot_fired at edge, hit 2 cycles later, score 0->1, ammo 3->2, hit_latched=1.
- Mouse (164,230), same duck -> miss (right edge exclusive), score unchanged; duck_x=2000, mouse_x=10 -> miss (no wrap).
- Four rises spaced past cooldown -> three shot_fired, fourth ignored, out_of_ammo=1 after third; rise during 8-frame cooldown ignored.
- round_start same cycle as rise -> no shot_fired, ammo=3, hit_latched cleared; score preset 99 plus hit -> stays 99.
- With CTL_SHOT_FLASH_EN: flash high from cycle after shot until 2nd new_frame; without: flash constant 0.

Source files
------------

// File: rtl/ctl_shot.sv
// -----------------------------------------------------------------------------
// ctl_shot -- shot controller for the duck game
//
// Samples the player's trigger and crosshair, checks the shot against the
// duck bounding box, and keeps track of ammo, cooldown, hit flag and score.
//
// Optional feature: define CTL_SHOT_FLASH_EN to build the screen-flash
// generator. When it is undefined, flash is tied low and no flash counter
// exists.
//
// Parameters
//   DUCK_W, DUCK_H   duck bounding box size in pixels
//   AMMO_MAX         shots per round (fits the 2-bit ammo output)
//   COOLDOWN_FRAMES  frames after a shot before the next trigger (1..63)
//   SCORE_MAX        score saturation value (fits the 7-bit score output)
//   FLASH_FRAMES     flash length in frames (only used with the flash feature)
//
// Ports
//   clk          system clock
//   rst          asynchronous active-low reset
//   new_frame    one-cycle pulse per video frame
//   round_start  one-cycle pulse: reload ammo, clear hit_latched, re-arm
//   trigger      mouse button level, already synchronous to clk
//   mouse_x/y    crosshair position (11 bit)
//   duck_x/y     duck top-left corner (11 bit)
//   duck_show    duck visible and shootable
//   shot_fired   one-cycle pulse per accepted shot
//   hit / miss   one-cycle result pulse, one cycle after shot_fired
//   hit_latched  high from a hit until the next round_start
//   ammo         remaining shots
//   out_of_ammo  ammo == 0
//   score        saturating hit counter
//   flash        screen flash request
// -----------------------------------------------------------------------------
module ctl_shot #(
   parameter int DUCK_W          = 64,
   parameter int DUCK_H          = 64,
   parameter int AMMO_MAX        = 3,
   parameter int COOLDOWN_FRAMES = 8,
   parameter int SCORE_MAX       = 99,
   parameter int FLASH_FRAMES    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        new_frame,
   input  logic        round_start,
   input  logic        trigger,
   input  logic [10:0] mouse_x,
   input  logic [10:0] mouse_y,
   input  logic [10:0] duck_x,
   input  logic [10:0] duck_y,
   input  logic        duck_show,
   output logic        shot_fired,
   output logic        hit,
   output logic        miss,
   output logic        hit_latched,
   output logic [1:0]  ammo,
   output logic        out_of_ammo,
   output logic [6:0]  score,
   output logic        flash
);

   // Elaboration-time parameter sanity checks.
   if (COOLDOWN_FRAMES < 1 || COOLDOWN_FRAMES > 63) begin : g_bad_cooldown
      $error("ctl_shot: COOLDOWN_FRAMES must be 1..63");
   end
   if (AMMO_MAX < 1 || AMMO_MAX > 3) begin : g_bad_ammo
      $error("ctl_shot: AMMO_MAX must be 1..3");
   end
   if (SCORE_MAX < 1 || SCORE_MAX > 127) begin : g_bad_score
      $error("ctl_shot: SCORE_MAX must be 1..127");
   end
   if (FLASH_FRAMES < 1) begin : g_bad_flash
      $error("ctl_shot: FLASH_FRAMES must be at least 1");
   end

   localparam logic [11:0] DUCK_W_L    = 12'(DUCK_W);
   localparam logic [11:0] DUCK_H_L    = 12'(DUCK_H);
   localparam logic [1:0]  AMMO_MAX_L  = 2'(AMMO_MAX);
   localparam logic [5:0]  CD_LAST_L   = 6'(COOLDOWN_FRAMES - 1);
   localparam logic [6:0]  SCORE_MAX_L = 7'(SCORE_MAX);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ARMED    = 2'd1,
      S_EVAL     = 2'd2,
      S_COOLDOWN = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        trigger_q;
   logic [10:0] mx_q, mx_d;
   logic [10:0] my_q, my_d;
   logic [10:0] dx_q, dx_d;
   logic [10:0] dy_q, dy_d;
   logic        show_q, show_d;
   logic [1:0]  ammo_q, ammo_d;
   logic [5:0]  cd_cnt_q, cd_cnt_d;
   logic        shot_q, shot_d;
   logic        hit_q, hit_d;
   logic        miss_q, miss_d;
   logic        hit_latched_q, hit_latched_d;
   logic [6:0]  score_q, score_d;

   logic        rise;
   logic        shot_hit;
   logic [11:0] mx_w, my_w, dx_w, dy_w;

   assign rise = trigger & ~trigger_q;

   // The box test runs in 12 bits so dx+DUCK_W near 2047 cannot wrap back
   // to a small value and turn a genuine hit into a miss.
   assign mx_w = {1'b0, mx_q};
   assign my_w = {1'b0, my_q};
   assign dx_w = {1'b0, dx_q};
   assign dy_w = {1'b0, dy_q};

   assign shot_hit = show_q
                   & (mx_w >= dx_w) & (mx_w < (dx_w + DUCK_W_L))
                   & (my_w >= dy_w) & (my_w < (dy_w + DUCK_H_L));

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      mx_d          = mx_q;
      my_d          = my_q;
      dx_d          = dx_q;
      dy_d          = dy_q;
      show_d        = show_q;
      ammo_d        = ammo_q;
      cd_cnt_d      = cd_cnt_q;
      shot_d        = 1'b0;
      hit_d         = 1'b0;
      miss_d        = 1'b0;
      hit_latched_d = hit_latched_q;
      score_d       = score_q;

      if (round_start) begin
         // round_start wins over everything: a coincident rise is dropped and
         // an evaluation in flight produces neither pulse nor score.
         state_d       = S_ARMED;
         ammo_d        = AMMO_MAX_L;
         hit_latched_d = 1'b0;
         cd_cnt_d      = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_IDLE;
            end

            S_ARMED: begin
               if (rise && (ammo_q != 2'd0)) begin
                  state_d = S_EVAL;
                  mx_d    = mouse_x;
                  my_d    = mouse_y;
                  dx_d    = duck_x;
                  dy_d    = duck_y;
                  show_d  = duck_show;
                  ammo_d  = ammo_q - 2'd1;
                  shot_d  = 1'b1;
               end
            end

            S_EVAL: begin
               state_d  = S_COOLDOWN;
               cd_cnt_d = '0;
               if (shot_hit) begin
                  hit_d         = 1'b1;
                  hit_latched_d = 1'b1;
                  if (score_q < SCORE_MAX_L) begin
                     score_d = score_q + 7'd1;
                  end
               end else begin
                  miss_d = 1'b1;
               end
            end

            S_COOLDOWN: begin
               if (new_frame) begin
                  if (cd_cnt_q == CD_LAST_L) begin
                     state_d  = S_ARMED;
                     cd_cnt_d = '0;
                  end else begin
                     cd_cnt_d = cd_cnt_q + 6'd1;
                  end
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         trigger_q     <= 1'b0;
         mx_q          <= '0;
         my_q          <= '0;
         dx_q          <= '0;
         dy_q          <= '0;
         show_q        <= 1'b0;
         ammo_q        <= '0;
         cd_cnt_q      <= '0;
         shot_q        <= 1'b0;
         hit_q         <= 1'b0;
         miss_q        <= 1'b0;
         hit_latched_q <= 1'b0;
         score_q       <= '0;
      end else begin
         state_q       <= state_d;
         trigger_q     <= trigger;
         mx_q          <= mx_d;
         my_q          <= my_d;
         dx_q          <= dx_d;
         dy_q          <= dy_d;
         show_q        <= show_d;
         ammo_q        <= ammo_d;
         cd_cnt_q      <= cd_cnt_d;
         shot_q        <= shot_d;
         hit_q         <= hit_d;
         miss_q        <= miss_d;
         hit_latched_q <= hit_latched_d;
         score_q       <= score_d;
      end
   end

   assign shot_fired  = shot_q;
   assign hit         = hit_q;
   assign miss        = miss_q;
   assign hit_latched = hit_latched_q;
   assign ammo        = ammo_q;
   assign out_of_ammo = (ammo_q == 2'd0);
   assign score       = score_q;

   // -------------------------------------------------------------------------
   // Screen flash
   // -------------------------------------------------------------------------
`ifdef CTL_SHOT_FLASH_EN
   localparam int FLASH_CW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
   localparam logic [FLASH_CW-1:0] FLASH_LAST_L = FLASH_CW'(FLASH_FRAMES - 1);

   logic                flash_q, flash_d;
   logic [FLASH_CW-1:0] flash_cnt_q, flash_cnt_d;

   // Flash rises the cycle after shot_fired; a later shot restarts the count
   // even if the previous flash is still running.
   always_comb begin
      flash_d     = flash_q;
      flash_cnt_d = flash_cnt_q;
      if (shot_q) begin
         flash_d     = 1'b1;
         flash_cnt_d = '0;
      end else if (flash_q && new_frame) begin
         if (flash_cnt_q == FLASH_LAST_L) begin
            flash_d     = 1'b0;
            flash_cnt_d = '0;
         end else begin
            flash_cnt_d = flash_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flash_q     <= 1'b0;
         flash_cnt_q <= '0;
      end else begin
         flash_q     <= flash_d;
         flash_cnt_q <= flash_cnt_d;
      end
   end

   assign flash = flash_q;
`else
   assign flash = 1'b0;
`endif

endmodule

// File: tb/tb_ctl_shot.sv
module tb_ctl_shot;

   logic        clk;
   logic        rst;
   logic        new_frame;
   logic        round_start;
   logic        trigger;
   logic [10:0] mouse_x;
   logic [10:0] mouse_y;
   logic [10:0] duck_x;
   logic [10:0] duck_y;
   logic        duck_show;
   logic        shot_fired;
   logic        hit;
   logic        miss;
   logic        hit_latched;
   logic [1:0]  ammo;
   logic        out_of_ammo;
   logic [6:0]  score;
   logic        flash;

`ifdef CTL_SHOT_FLASH_EN
   localparam logic FLASH_ON = 1'b1;
`else
   localparam logic FLASH_ON = 1'b0;
`endif

   ctl_shot dut (
      .clk         (clk),
      .rst         (rst),
      .new_frame   (new_frame),
      .round_start (round_start),
      .trigger     (trigger),
      .mouse_x     (mouse_x),
      .mouse_y     (mouse_y),
      .duck_x      (duck_x),
      .duck_y      (duck_y),
      .duck_show   (duck_show),
      .shot_fired  (shot_fired),
      .hit         (hit),
      .miss        (miss),
      .hit_latched (hit_latched),
      .ammo        (ammo),
      .out_of_ammo (out_of_ammo),
      .score       (score),
      .flash       (flash)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Bench-side model state
   int   exp_ammo    = 0;
   int   exp_score   = 0;
   logic exp_latched = 1'b0;

   typedef struct {
      logic is_hit;
      int   score_after;
      int   mx;
      int   my;
   } exp_t;
   exp_t sb[$];

   // Result monitor: every hit/miss pulse pops one expectation.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (hit === 1'b1 && miss === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL hit_and_miss: got hit=1 miss=1, required exactly one");
      end else if (hit === 1'b1 || miss === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got hit=%0b miss=%0b, required no pulse", hit, miss);
         end else begin
            e = sb.pop_front();
            $display("shot (%0d,%0d): hit=%0b score=%0d", e.mx, e.my, hit, score);
            if (hit !== e.is_hit) begin
               errors++;
               $display("FAIL shot_result: got hit=%0b, required %0b", hit, e.is_hit);
            end
            checks++;
            if (score !== 7'(e.score_after)) begin
               errors++;
               $display("FAIL shot_score: got %0d, required %0d", score, e.score_after);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_round();
      round_start = 1'b1;
      step();
      round_start = 1'b0;
      exp_ammo    = 3;
      exp_latched = 1'b0;
   endtask

   task automatic cooldown(input int n);
      new_frame = 1'b1;
      repeat (n) step();
      new_frame = 1'b0;
   endtask

   // Present a trigger rise with the given geometry; leaves the bench in the
   // cycle where hit/miss is visible (if the shot was accepted).
   task automatic fire(input int mx, input int my, input int dx, input int dy,
                       input logic show, input logic accept, input string tag);
      exp_t e;
      mouse_x   = 11'(mx);
      mouse_y   = 11'(my);
      duck_x    = 11'(dx);
      duck_y    = 11'(dy);
      duck_show = show;
      trigger   = 1'b1;
      if (accept) begin
         e.is_hit = show && (mx >= dx) && (mx < dx + 64) && (my >= dy) && (my < dy + 64);
         if (e.is_hit) begin
            if (exp_score < 99) exp_score++;
            exp_latched = 1'b1;
         end
         e.score_after = exp_score;
         e.mx = mx;
         e.my = my;
         sb.push_back(e);
         exp_ammo--;
      end
      step();
      checks++;
      if (shot_fired !== accept) begin
         errors++;
         $display("FAIL %s shot_fired: got %0b, required %0b", tag, shot_fired, accept);
      end
      checks++;
      if (ammo !== 2'(exp_ammo)) begin
         errors++;
         $display("FAIL %s ammo: got %0d, required %0d", tag, ammo, exp_ammo);
      end
      // Inputs move after the latch edge; the result must not follow them.
      mouse_x   = 11'd0;
      mouse_y   = 11'd0;
      duck_x    = 11'd2047;
      duck_show = ~show;
      trigger   = 1'b0;
      step();
      checks++;
      if (hit_latched !== exp_latched) begin
         errors++;
         $display("FAIL %s hit_latched: got %0b, required %0b", tag, hit_latched, exp_latched);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1 rst = 1'b0;
      #1;
      checks++;
      if ({ammo, score, out_of_ammo, hit_latched, shot_fired, hit, miss, flash} !== {2'd0, 7'd0, 1'b1, 5'b0}) begin
         errors++;
         $display("FAIL reset_values: got ammo=%0d score=%0d ooa=%0b hl=%0b sf=%0b h=%0b m=%0b fl=%0b, required 0 0 1 0 0 0 0 0",
                  ammo, score, out_of_ammo, hit_latched, shot_fired, hit, miss, flash);
      end
      repeat (2) step();
      rst = 1'b1;
      step();
      checks++;
      if (ammo !== 2'd0 || out_of_ammo !== 1'b1) begin
         errors++;
         $display("FAIL idle_ammo: got ammo=%0d ooa=%0b, required 0 1", ammo, out_of_ammo);
      end

      // Reset asserted while a shot is being evaluated.
      pulse_round();
      mouse_x = 11'd130; mouse_y = 11'd230; duck_x = 11'd100; duck_y = 11'd200; duck_show = 1'b1;
      trigger = 1'b1;
      step();
      checks++;
      if (shot_fired !== 1'b1) begin
         errors++;
         $display("FAIL mid_eval_shot: got %0b, required 1", shot_fired);
      end
      trigger = 1'b0;
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({ammo, score, out_of_ammo, hit_latched, shot_fired, hit, miss, flash} !== {2'd0, 7'd0, 1'b1, 5'b0}) begin
         errors++;
         $display("FAIL mid_eval_reset: got ammo=%0d score=%0d ooa=%0b hl=%0b sf=%0b h=%0b m=%0b fl=%0b, required 0 0 1 0 0 0 0 0",
                  ammo, score, out_of_ammo, hit_latched, shot_fired, hit, miss, flash);
      end
      repeat (2) begin
         step();
         checks++;
         if (hit !== 1'b0 || miss !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_pulse: got hit=%0b miss=%0b, required 0 0", hit, miss);
         end
      end
      #3 rst = 1'b1;
      exp_ammo = 0; exp_score = 0; exp_latched = 1'b0;
      repeat (2) step();
      fire(130, 230, 100, 200, 1'b1, 1'b0, "idle_rise");
      checks++;
      if (ammo !== 2'd0) begin
         errors++;
         $display("FAIL after_reset_ammo: got %0d, required 0", ammo);
      end
   endtask

   task automatic test_hit();
      pulse_round();
      checks++;
      if (ammo !== 2'd3 || out_of_ammo !== 1'b0) begin
         errors++;
         $display("FAIL reload: got ammo=%0d ooa=%0b, required 3 0", ammo, out_of_ammo);
      end
      fire(130, 230, 100, 200, 1'b1, 1'b1, "basic_hit");
      checks++;
      if (score !== 7'd1) begin
         errors++;
         $display("FAIL basic_hit_score: got %0d, required 1", score);
      end
      cooldown(8);
   endtask

   task automatic test_box_edges();
      fire(164, 230, 100, 200, 1'b1, 1'b1, "right_edge");
      cooldown(8);
      fire(10, 230, 2000, 200, 1'b1, 1'b1, "no_wrap_low");
      cooldown(8);
      pulse_round();
      fire(2040, 230, 2000, 200, 1'b1, 1'b1, "no_wrap_high");
      cooldown(8);
      fire(163, 263, 100, 200, 1'b1, 1'b1, "inner_corner");
      cooldown(8);
      fire(130, 230, 100, 200, 1'b0, 1'b1, "hidden_duck");
      cooldown(8);
      pulse_round();
      fire(130, 264, 100, 200, 1'b1, 1'b1, "bottom_edge");
      cooldown(8);
      fire(99, 230, 100, 200, 1'b1, 1'b1, "left_edge");
      cooldown(8);
   endtask

   task automatic test_ammo_cooldown();
      pulse_round();
      fire(120, 220, 100, 200, 1'b1, 1'b1, "ammo_1");
      cooldown(7);
      fire(120, 220, 100, 200, 1'b1, 1'b0, "cooldown_rise");
      cooldown(1);
      fire(120, 220, 100, 200, 1'b1, 1'b1, "ammo_2");
      cooldown(8);
      fire(300, 220, 100, 200, 1'b1, 1'b1, "ammo_3");
      checks++;
      if (out_of_ammo !== 1'b1) begin
         errors++;
         $display("FAIL out_of_ammo: got %0b, required 1", out_of_ammo);
      end
      cooldown(8);
      fire(120, 220, 100, 200, 1'b1, 1'b0, "ammo_4");
   endtask

   task automatic test_round_start_priority();
      mouse_x = 11'd130; mouse_y = 11'd230; duck_x = 11'd100; duck_y = 11'd200; duck_show = 1'b1;
      round_start = 1'b1;
      trigger     = 1'b1;
      step();
      round_start = 1'b0;
      trigger     = 1'b0;
      exp_ammo    = 3;
      exp_latched = 1'b0;
      checks++;
      if (shot_fired !== 1'b0 || ammo !== 2'd3 || hit_latched !== 1'b0) begin
         errors++;
         $display("FAIL round_vs_rise: got sf=%0b ammo=%0d hl=%0b, required 0 3 0", shot_fired, ammo, hit_latched);
      end
      step();
      checks++;
      if (shot_fired !== 1'b0) begin
         errors++;
         $display("FAIL round_vs_rise_late: got sf=%0b, required 0", shot_fired);
      end
      step();
   endtask

   task automatic test_flash();
      pulse_round();
      cooldown(2);
      checks++;
      if (flash !== 1'b0) begin
         errors++;
         $display("FAIL flash_idle: got %0b, required 0", flash);
      end
      fire(130, 230, 100, 200, 1'b1, 1'b1, "flash_shot");
      checks++;
      if (flash !== FLASH_ON) begin
         errors++;
         $display("FAIL flash_on: got %0b, required %0b", flash, FLASH_ON);
      end
      new_frame = 1'b1;
      step();
      checks++;
      if (flash !== FLASH_ON) begin
         errors++;
         $display("FAIL flash_frame1: got %0b, required %0b", flash, FLASH_ON);
      end
      step();
      new_frame = 1'b0;
      checks++;
      if (flash !== 1'b0) begin
         errors++;
         $display("FAIL flash_frame2: got %0b, required 0", flash);
      end
      cooldown(6);
   endtask

   task automatic test_saturation();
      while (exp_score < 99) begin
         pulse_round();
         fire(130, 230, 100, 200, 1'b1, 1'b1, "fill");
      end
      pulse_round();
      fire(130, 230, 100, 200, 1'b1, 1'b1, "saturate");
      checks++;
      if (score !== 7'd99) begin
         errors++;
         $display("FAIL saturate_score: got %0d, required 99", score);
      end
   endtask

   initial begin
      rst = 1'b1; new_frame = 1'b0; round_start = 1'b0; trigger = 1'b0;
      mouse_x = '0; mouse_y = '0; duck_x = '0; duck_y = '0; duck_show = 1'b0;

      test_reset();
      test_hit();
      test_box_edges();
      test_ammo_cooldown();
      test_round_start_priority();
      test_flash();
      test_saturation();

      repeat (4) step();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL outstanding_results: got %0d pending, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
